// File: rtl/penc_match_serializer.sv
// Captures one vector of per-bin encoder results and drains the surviving bins,
// lowest bin first, onto a valid/ready match stream; errored bins are counted.
module penc_match_serializer #(
  parameter int BIN_COUNT     = 8,
  parameter int OUTPUT_WIDTH  = 13,
  parameter int BIN_WIDTH     = 3,
  parameter int TAG_WIDTH     = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BIN_COUNT*OUTPUT_WIDTH-1:0] in_index,
  input  logic [BIN_COUNT-1:0]              in_bin_valid,
  input  logic [BIN_COUNT-1:0]              in_error,
  input  logic [TAG_WIDTH-1:0]              in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUTPUT_WIDTH-1:0]           out_index,
  output logic [BIN_WIDTH-1:0]              out_bin,
  output logic [TAG_WIDTH-1:0]              out_tag,
  output logic                              out_last,
  input  logic                              err_clear,
  output logic [ERR_CNT_WIDTH-1:0]          err_count
);

  logic [BIN_COUNT-1:0]     pend_q, pend_d;
  logic [OUTPUT_WIDTH-1:0]  idx_q [BIN_COUNT];
  logic [TAG_WIDTH-1:0]     tag_q;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic [BIN_WIDTH-1:0]     low_bin;
  logic [BIN_WIDTH:0]       err_pop;
  logic [ERR_CNT_WIDTH:0]   err_sum;
  logic                     last;
  logic                     fire;
  logic                     accept;

  // Downward scan so the last assignment wins: lowest pending bin.
  always_comb begin
    low_bin = '0;
    for (int i = BIN_COUNT - 1; i >= 0; i--) begin
      if (pend_q[i]) low_bin = BIN_WIDTH'(i);
    end
  end

  always_comb begin
    err_pop = '0;
    for (int i = 0; i < BIN_COUNT; i++) begin
      err_pop = err_pop + (BIN_WIDTH + 1)'(in_error[i]);
    end
  end

  assign last      = (pend_q != '0) && ((pend_q & (pend_q - BIN_COUNT'(1))) == '0);
  assign out_valid = !rst && (pend_q != '0);
  assign fire      = out_valid && out_ready;
  assign in_ready  = !rst && ((pend_q == '0) || (fire && last));
  assign accept    = in_valid && in_ready;

  assign out_bin   = low_bin;
  assign out_index = idx_q[low_bin];
  assign out_tag   = tag_q;
  assign out_last  = last;
  assign err_count = err_q;

  assign err_sum = {1'b0, err_q} + (ERR_CNT_WIDTH + 1)'(err_pop);

  always_comb begin
    pend_d = pend_q;
    if (fire) pend_d[low_bin] = 1'b0;
    // A fresh vector replaces the mask outright, including the final-handshake cycle.
    if (accept) pend_d = in_bin_valid & ~in_error;
  end

  always_comb begin
    err_d = err_q;
    if (err_clear) begin
      err_d = '0;
    end else if (accept) begin
      err_d = err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      err_q  <= '0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  generate
    for (genvar gi = 0; gi < BIN_COUNT; gi++) begin : g_idx
      always_ff @(posedge clk) begin
        if (accept) idx_q[gi] <= in_index[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) tag_q <= in_tag;
  end

endmodule

// File: tb/tb_penc_match_serializer.sv
// Randomised and directed bench: a queue of expected matches plus an error total
// model what the serializer must emit, checked every cycle.
module tb_penc_match_serializer;
  localparam int BC = 8;
  localparam int OW = 13;
  localparam int BW = 3;
  localparam int TW = 8;
  localparam int EW = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [BC*OW-1:0]   in_index;
  logic [BC-1:0]      in_bin_valid;
  logic [BC-1:0]      in_error;
  logic [TW-1:0]      in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [OW-1:0]      out_index;
  logic [BW-1:0]      out_bin;
  logic [TW-1:0]      out_tag;
  logic               out_last;
  logic               err_clear;
  logic [EW-1:0]      err_count;

  always #5 clk = ~clk;

  penc_match_serializer #(
    .BIN_COUNT(BC), .OUTPUT_WIDTH(OW), .BIN_WIDTH(BW), .TAG_WIDTH(TW), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
    .in_bin_valid(in_bin_valid), .in_error(in_error), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_bin(out_bin), .out_tag(out_tag), .out_last(out_last),
    .err_clear(err_clear), .err_count(err_count)
  );

  typedef struct {
    logic [BC*OW-1:0] idx;
    logic [BC-1:0]    bv;
    logic [BC-1:0]    er;
    logic [TW-1:0]    tag;
  } vec_t;

  typedef struct {
    int bin;
    int index;
    int tag;
    bit last;
  } match_t;

  vec_t   srcq[$];
  match_t expq[$];
  int     err_m;
  int     checks;
  int     errors;
  int     rdy_mode;
  bit     rdy_tog;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mkvec(input logic [BC-1:0] bv, input logic [BC-1:0] er,
                                 input logic [TW-1:0] tag);
    vec_t v;
    for (int b = 0; b < BC; b++) v.idx[b*OW +: OW] = OW'($urandom);
    v.bv  = bv;
    v.er  = er;
    v.tag = tag;
    return v;
  endfunction

  // One clock: drive, check at negedge, advance the model at posedge.
  task automatic cycle();
    vec_t   v;
    match_t m;
    bit     exp_valid, exp_ready, acc, fire;
    int     last_i;
    if (rdy_mode == 1) begin
      out_ready = rdy_tog;
      rdy_tog   = ~rdy_tog;
    end else if (rdy_mode == 2) begin
      out_ready = 1'($urandom);
    end
    if (srcq.size() > 0) begin
      v = srcq[0];
      in_valid = 1'b1;
    end else begin
      v = mkvec(BC'($urandom), BC'($urandom), TW'($urandom));
      in_valid = 1'b0;
    end
    in_index     = v.idx;
    in_bin_valid = v.bv;
    in_error     = v.er;
    in_tag       = v.tag;

    @(negedge clk);
    exp_valid = !rst && (expq.size() > 0);
    exp_ready = !rst && ((expq.size() == 0) || (expq.size() == 1 && out_ready));
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("err_count", 32'(err_count), 32'(err_m));
    if (exp_valid) begin
      m = expq[0];
      chk("out_bin", 32'(out_bin), 32'(m.bin));
      chk("out_index", 32'(out_index), 32'(m.index));
      chk("out_tag", 32'(out_tag), 32'(m.tag));
      chk("out_last", 32'(out_last), 32'(m.last));
      $display("t=%0t match bin=%0d index=%0d tag=%0h last=%0b ready=%0b",
               $time, out_bin, out_index, out_tag, out_last, out_ready);
    end
    acc  = in_valid && exp_ready;
    fire = exp_valid && out_ready;

    @(posedge clk);
    if (rst) begin
      expq.delete();
      err_m = 0;
    end else begin
      if (fire) void'(expq.pop_front());
      if (err_clear) err_m = 0;
      else if (acc) err_m = (err_m + $countones(v.er) > 65535) ? 65535 : err_m + $countones(v.er);
      if (acc) begin
        void'(srcq.pop_front());
        last_i = -1;
        for (int b = 0; b < BC; b++) begin
          if (v.bv[b] && !v.er[b]) begin
            m.bin   = b;
            m.index = int'(v.idx[b*OW +: OW]);
            m.tag   = int'(v.tag);
            m.last  = 1'b0;
            expq.push_back(m);
            last_i = expq.size() - 1;
          end
        end
        if (last_i >= 0) expq[last_i].last = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drain(input int mode);
    int n;
    rdy_mode = mode;
    n = 0;
    while ((srcq.size() > 0 || expq.size() > 0) && n < 20000) begin
      cycle();
      n++;
    end
    checks++;
    assert (srcq.size() == 0 && expq.size() == 0)
    else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", expq.size() + srcq.size());
    end
    rdy_mode  = 0;
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t v;
    checks    = 0;
    errors    = 0;
    err_m     = 0;
    rdy_mode  = 0;
    rdy_tog   = 1'b0;
    rst       = 1'b1;
    err_clear = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_index  = '0;
    in_bin_valid = '0;
    in_error  = '0;
    in_tag    = '0;
    @(posedge clk);
    #1;

    // Reset held with a vector offered; it is taken only after release.
    srcq.push_back(mkvec(8'h03, 8'h00, 8'h11));
    repeat (3) cycle();
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    drain(0);

    // Single vector with fixed indices.
    v = mkvec(8'b1010_0100, 8'h00, 8'h3C);
    v.idx[2*OW +: OW] = 13'd5;
    v.idx[5*OW +: OW] = 13'd77;
    v.idx[7*OW +: OW] = 13'd8191;
    srcq.push_back(v);
    drain(0);

    // Same vector under toggling backpressure.
    srcq.push_back(v);
    drain(1);

    // Errored bins dropped and counted.
    srcq.push_back(mkvec(8'hFF, 8'h11, 8'h5A));
    drain(0);
    chk("err_after_0x11", 32'(err_count), 32'd2);

    // Back-to-back stream with an empty vector in the middle.
    srcq.push_back(mkvec(8'h03, 8'h00, 8'hA0));
    srcq.push_back(mkvec(8'h00, 8'h00, 8'hE0));
    srcq.push_back(mkvec(8'h10, 8'h00, 8'hB0));
    drain(0);

    // Random traffic.
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && srcq.size() < 3)
        srcq.push_back(mkvec(BC'($urandom), BC'($urandom_range(0, 3) == 0 ? $urandom : 0),
                             TW'($urandom)));
      err_clear = ($urandom_range(0, 19) == 0);
      cycle();
    end
    err_clear = 1'b0;
    drain(2);

    // Saturation: clear, preload to 0xFFFE, then overflow.
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    for (int i = 0; i < 8191; i++) srcq.push_back(mkvec(8'h00, 8'hFF, 8'h00));
    srcq.push_back(mkvec(8'h00, 8'h3F, 8'h00));
    drain(0);
    chk("err_preload", 32'(err_count), 32'hFFFE);
    srcq.push_back(mkvec(8'hFF, 8'h11, 8'h77));
    drain(0);
    chk("err_saturate", 32'(err_count), 32'hFFFF);
    srcq.push_back(mkvec(8'h00, 8'hFF, 8'h00));
    drain(0);
    chk("err_hold_sat", 32'(err_count), 32'hFFFF);

    // Clear wins over errors accepted in the same cycle.
    srcq.push_back(mkvec(8'h00, 8'h01, 8'h00));
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    chk("err_clear_priority", 32'(err_count), 32'd0);

    // Reset in the middle of a drain discards pending matches.
    srcq.push_back(mkvec(8'hFF, 8'h00, 8'hC3));
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_drain_valid", 32'(out_valid), 32'd0);
    cycle();
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
